// File: rtl/io_display_pkg.sv
// ============================================================================
// Module   : io_display_pkg
// Brief    : Shared constants, FSM encoding and segment decode for the display
// Revision : 1.0
// ============================================================================
`default_nettype none

package io_display_pkg;

  localparam logic [2:0] AN_D0 = 3'b110;
  localparam logic [2:0] AN_D1 = 3'b101;
  localparam logic [2:0] AN_D2 = 3'b011;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low gfedcba patterns; entry [n] displays hex digit n.
  localparam logic [15:0][6:0] SEG_PATTERNS = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    return SEG_PATTERNS[nibble];
  endfunction

  function automatic logic [2:0] anode_code(input logic [1:0] idx);
    logic [2:0] code;
    case (idx)
      2'd1:    code = AN_D1;
      2'd2:    code = AN_D2;
      default: code = AN_D0;
    endcase
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_dabble.sv
// ============================================================================
// Module   : bcd_dabble
// Brief    : Sequential shift-add-3 binary to 3-digit BCD converter
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_dabble
  import io_display_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              done,
  output logic [11:0]       bcd
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

  conv_state_t       r_state;
  conv_state_t       w_next_state;
  logic [DATA_W-1:0] r_shift;
  logic [11:0]       r_bcd;
  logic [3:0]        r_bit_cnt;
  logic [10:0]       w_adj;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = CONV;
      CONV:    if (r_bit_cnt == LAST_BIT) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Hundreds never exceed 2 before a shift for DATA_W <= 9, so only the
  // units and tens nibbles ever need the add-3 correction.
  always_comb begin
    w_adj        = r_bcd[10:0];
    if (r_bcd[3:0] >= 4'd5) w_adj[3:0] = r_bcd[3:0] + 4'd3;
    if (r_bcd[7:4] >= 4'd5) w_adj[7:4] = r_bcd[7:4] + 4'd3;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_shift   <= '0;
      r_bcd     <= '0;
      r_bit_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shift   <= data;
            r_bcd     <= '0;
            r_bit_cnt <= '0;
          end
        end
        CONV: begin
          r_bcd     <= {w_adj, r_shift[DATA_W-1]};
          r_shift   <= r_shift << 1;
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign ready = (r_state == IDLE);
  assign done  = (r_state == DONE);
  assign bcd   = r_bcd;

endmodule

`default_nettype wire

// File: rtl/io_display_driver.sv
// ============================================================================
// Module   : io_display_driver
// Brief    : Latches the core's display-port value and scans it onto a
//            3-digit active-low 7-segment display.
// Config   : BCD_CONV_EN selects decimal display through bcd_dabble;
//            undefined gives hex display with wr_ready tied high.
// Revision : 1.0
// ============================================================================
`default_nettype none

module io_display_driver
  import io_display_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [6:0]        io_display,
  output logic [2:0]        an
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_refresh_cnt;
  logic [1:0]       r_digit_idx;
  logic [11:0]      r_digits;
  logic [3:0]       w_cur_nibble;
  logic             w_load;
  logic [11:0]      w_load_value;

`ifdef BCD_CONV_EN
  bcd_dabble #(
    .DATA_W (DATA_W)
  ) u_bcd_dabble (
    .clock (clock),
    .reset (reset),
    .start (wr_en),
    .data  (wr_data),
    .ready (wr_ready),
    .done  (w_load),
    .bcd   (w_load_value)
  );
`else
  assign wr_ready     = 1'b1;
  assign w_load       = wr_en;
  assign w_load_value = 12'(wr_data);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= '0;
    end else if (r_refresh_cnt == CNT_LAST) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= (r_digit_idx == 2'd2) ? 2'd0 : r_digit_idx + 2'd1;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_digits <= '0;
    end else if (w_load) begin
      r_digits <= w_load_value;
    end
  end

  always_comb begin
    w_cur_nibble = r_digits[3:0];
    case (r_digit_idx)
      2'd1:    w_cur_nibble = r_digits[7:4];
      2'd2:    w_cur_nibble = r_digits[11:8];
      default: w_cur_nibble = r_digits[3:0];
    endcase
  end

  // Anode and segments share one register stage so they always switch together.
  always_ff @(posedge clock) begin
    if (reset) begin
      an         <= AN_D0;
      io_display <= SEG_PATTERNS[0];
    end else begin
      an         <= anode_code(r_digit_idx);
      io_display <= seg_decode(w_cur_nibble);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_io_display_driver.sv
// ============================================================================
// Module   : tb_io_display_driver
// Brief    : Scoreboard bench for io_display_driver (DATA_W=8, REFRESH_DIV=4)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_io_display_driver;

  localparam int R = 3;

  logic       clock   = 1'b0;
  logic       reset   = 1'b1;
  logic       wr_en   = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready;
  logic [6:0] io_display;
  logic [2:0] an;

  io_display_driver #(
    .DATA_W      (8),
    .REFRESH_DIV (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .io_display (io_display),
    .an         (an)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] an;
    logic [6:0] seg;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SC = 7'b1000110;
  localparam logic [6:0] SF = 7'b0001110;

  task automatic exp_span(input int k0, input int k1, input logic [2:0] a,
                          input logic [6:0] s, input logic r);
    for (int k = k0; k <= k1; k++) begin
      exp_t e;
      e.cyc = R + k;
      e.an  = a;
      e.seg = s;
      e.rdy = r;
      q.push_back(e);
    end
  endtask

  // Returns at the falling edge just before relative edge k.
  task automatic goto(input int k);
    while (cyc != R + k - 1) @(negedge clock);
  endtask

  task automatic write_at(input int k, input logic [7:0] d);
    goto(k);
    wr_en   = 1'b1;
    wr_data = d;
    goto(k + 1);
    wr_en   = 1'b0;
  endtask

  always @(posedge clock) begin
    #1;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (e.cyc != cyc || an !== e.an || io_display !== e.seg || wr_ready !== e.rdy) begin
        n_fail++;
        $display("FAIL scan@%0d (now %0d): got an=%b seg=%b rdy=%b, want an=%b seg=%b rdy=%b",
                 e.cyc - R, cyc - R, an, io_display, wr_ready, e.an, e.seg, e.rdy);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
`ifdef BCD_CONV_EN
    exp_span( 0,  1, 3'b110, S0, 1'b1);
    exp_span( 2,  4, 3'b110, S0, 1'b0);
    exp_span( 5,  8, 3'b101, S0, 1'b0);
    exp_span( 9, 10, 3'b011, S0, 1'b0);
    exp_span(11, 11, 3'b011, S0, 1'b1);
    exp_span(12, 12, 3'b011, S2, 1'b1);
    exp_span(13, 16, 3'b110, S5, 1'b1);
    exp_span(17, 20, 3'b101, S5, 1'b1);
    exp_span(21, 24, 3'b011, S2, 1'b1);
    exp_span(25, 25, 3'b110, S5, 1'b1);
    exp_span(26, 28, 3'b110, S5, 1'b0);
    exp_span(29, 32, 3'b101, S5, 1'b0);
    exp_span(33, 34, 3'b011, S2, 1'b0);
    exp_span(35, 35, 3'b011, S2, 1'b1);
    exp_span(36, 36, 3'b011, S0, 1'b1);
    exp_span(37, 40, 3'b110, S9, 1'b1);
    exp_span(41, 44, 3'b101, S0, 1'b1);
    exp_span(45, 48, 3'b011, S0, 1'b1);
    exp_span(49, 51, 3'b110, S9, 1'b1);
    exp_span(52, 52, 3'b110, S9, 1'b0);
    exp_span(53, 56, 3'b101, S0, 1'b0);
    exp_span(57, 61, 3'b110, S0, 1'b1);
    exp_span(62, 65, 3'b101, S0, 1'b1);
    exp_span(66, 69, 3'b011, S0, 1'b1);

    goto(1);
    reset = 1'b0;
    write_at(2, 8'd255);
    write_at(26, 8'd9);
    write_at(28, 8'd200);
    write_at(52, 8'd123);
    goto(57);
    reset = 1'b1;
    goto(58);
    reset = 1'b0;
    goto(73);
`else
    exp_span( 0,  2, 3'b110, S0, 1'b1);
    exp_span( 3,  3, 3'b110, SC, 1'b1);
    exp_span( 4,  4, 3'b110, SF, 1'b1);
    exp_span( 5,  8, 3'b101, S7, 1'b1);
    exp_span( 9, 12, 3'b011, S0, 1'b1);
    exp_span(13, 14, 3'b110, SF, 1'b1);
    exp_span(15, 16, 3'b110, S5, 1'b1);
    exp_span(17, 20, 3'b101, SA, 1'b1);
    exp_span(21, 24, 3'b011, S0, 1'b1);
    exp_span(25, 28, 3'b110, S5, 1'b1);
    exp_span(29, 32, 3'b101, SA, 1'b1);
    exp_span(33, 33, 3'b011, S0, 1'b1);
    exp_span(34, 38, 3'b110, S0, 1'b1);
    exp_span(39, 42, 3'b101, S0, 1'b1);

    goto(1);
    reset = 1'b0;
    write_at(2, 8'h3C);
    write_at(3, 8'h7F);
    write_at(14, 8'hA5);
    goto(34);
    reset = 1'b1;
    goto(35);
    reset = 1'b0;
    goto(46);
`endif
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
